// File: rtl/seg7_scanner.sv
// Time-multiplexed 7-segment scanner: shared segment bus plus per-digit
// anode enables, with a once-per-frame snapshot and per-slot blanking gap.
module seg7_scanner #(
  parameter int NUM_7SEGMENTS = 8,
  parameter int DIGIT_CYCLES  = 50000,
  parameter int BLANK_CYCLES  = 500,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_en,
  input  logic [6:0]               i_hex [0:NUM_7SEGMENTS-1],
  output logic [6:0]               o_seg,
  output logic [NUM_7SEGMENTS-1:0] o_an,
  output logic                     o_frame_start
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int DW = (NUM_7SEGMENTS > 1) ? $clog2(NUM_7SEGMENTS) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ON  = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_MAX = DW'(NUM_7SEGMENTS - 1);

  localparam logic [NUM_7SEGMENTS-1:0] AN_OFF =
    {NUM_7SEGMENTS{AN_ACTIVE_LOW}};

  typedef enum logic {BLANK, ON} phase_t;

  logic                     run;
  logic [CW-1:0]            cnt;
  logic [DW-1:0]            dig;
  phase_t                   phase;
  logic [6:0]               shadow [0:NUM_7SEGMENTS-1];

  logic [CW-1:0]            cnt_n;
  logic [DW-1:0]            dig_n;
  logic                     wrap;
  phase_t                   phase_n;
  logic [NUM_7SEGMENTS-1:0] sel;
  logic [NUM_7SEGMENTS-1:0] an_on;
  logic [6:0]               seg_on;

  // Position of the cycle this edge begins; !run means a fresh start.
  always_comb begin
    cnt_n = '0;
    dig_n = '0;
    if (run) begin
      if (cnt == CNT_MAX) begin
        cnt_n = '0;
        dig_n = (dig == DIG_MAX) ? '0 : dig + 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
        dig_n = dig;
      end
    end
    wrap = (cnt_n == '0) && (dig_n == '0);

    phase_n = phase;
    if (cnt_n == '0)
      phase_n = (CNT_ON == '0) ? ON : BLANK;
    else if (cnt_n == CNT_ON)
      phase_n = ON;

    sel = '0;
    sel[dig_n] = 1'b1;
    an_on = AN_ACTIVE_LOW ? ~sel : sel;
    // The snapshot lands on this same edge, so bypass it at frame start.
    seg_on = wrap ? i_hex[0] : shadow[dig_n];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      run           <= 1'b0;
      cnt           <= '0;
      dig           <= '0;
      phase         <= BLANK;
      shadow        <= '{default: 7'h7f};
      o_seg         <= 7'h7f;
      o_an          <= AN_OFF;
      o_frame_start <= 1'b0;
    end else if (!i_en) begin
      run           <= 1'b0;
      cnt           <= '0;
      dig           <= '0;
      phase         <= BLANK;
      o_seg         <= 7'h7f;
      o_an          <= AN_OFF;
      o_frame_start <= 1'b0;
    end else begin
      run           <= 1'b1;
      cnt           <= cnt_n;
      dig           <= dig_n;
      phase         <= phase_n;
      o_frame_start <= wrap;
      if (wrap)
        shadow <= i_hex;
      if (phase_n == ON) begin
        o_seg <= seg_on;
        o_an  <= an_on;
      end else begin
        o_seg <= 7'h7f;
        o_an  <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner: N=4, D=8, with B=2 and B=0 instances
// driven from the same stimulus.
module tb_seg7_scanner;

  logic       clk;
  logic       n_rst;
  logic       en;
  logic [6:0] hex [0:3];
  logic [6:0] seg1, seg2;
  logic [3:0] an1, an2;
  logic       fs1, fs2;

  seg7_scanner #(
    .NUM_7SEGMENTS(4), .DIGIT_CYCLES(8),
    .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_en(en), .i_hex(hex),
    .o_seg(seg1), .o_an(an1), .o_frame_start(fs1)
  );

  seg7_scanner #(
    .NUM_7SEGMENTS(4), .DIGIT_CYCLES(8),
    .BLANK_CYCLES(0), .AN_ACTIVE_LOW(1'b1)
  ) dut_nb (
    .clk(clk), .n_rst(n_rst), .i_en(en), .i_hex(hex),
    .o_seg(seg2), .o_an(an2), .o_frame_start(fs2)
  );

  typedef struct {
    int         cyc;
    bit         chk2;
    logic [6:0] seg1;
    logic [3:0] an1;
    logic       fs1;
    logic [6:0] seg2;
    logic [3:0] an2;
    logic       fs2;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int c = 0;
  logic [6:0] sh [0:3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
               name, cyc, act, exp);
    end
  endtask

  // Reference: cycle c of a run is slot (c/8)%4, position c%8.
  task automatic tick();
    exp_t e;
    int slot, p;
    e.cyc = c; e.chk2 = 1'b1;
    e.seg1 = 7'h7f; e.an1 = 4'b1111; e.fs1 = 1'b0;
    e.seg2 = 7'h7f; e.an2 = 4'b1111; e.fs2 = 1'b0;
    if (!n_rst || !en) begin
      c = 0;
    end else begin
      if (c % 32 == 0) sh = hex;
      slot = (c / 8) % 4;
      p = c % 8;
      e.fs1 = (c % 32 == 0);
      e.fs2 = e.fs1;
      if (p >= 2) begin
        e.seg1 = sh[slot];
        e.an1 = ~(4'b0001 << slot);
      end
      e.seg2 = sh[slot];
      e.an2 = ~(4'b0001 << slot);
      e.chk2 = (c != 0);
      c++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_off(input string tag);
    chk({tag, "_seg"}, c, 32'(seg1), 32'h7f);
    chk({tag, "_an"}, c, 32'(an1), 32'hf);
    chk({tag, "_fs"}, c, 32'(fs1), 32'h0);
    chk({tag, "_seg_nb"}, c, 32'(seg2), 32'h7f);
    chk({tag, "_an_nb"}, c, 32'(an2), 32'hf);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("seg", e.cyc, 32'(seg1), 32'(e.seg1));
        chk("an", e.cyc, 32'(an1), 32'(e.an1));
        chk("frame_start", e.cyc, 32'(fs1), 32'(e.fs1));
        chk("frame_start_nb", e.cyc, 32'(fs2), 32'(e.fs2));
        if (e.chk2) begin
          chk("seg_nb", e.cyc, 32'(seg2), 32'(e.seg2));
          chk("an_nb", e.cyc, 32'(an2), 32'(e.an2));
        end
      end
    end
  end

  initial begin : stim
    n_rst = 1'b0;
    en = 1'b1;
    hex[0] = 7'h40; hex[1] = 7'h79;
    hex[2] = 7'h24; hex[3] = 7'h30;
    sh = '{default: 7'h7f};
    @(negedge clk);
    check_off("reset");
    ticks(3);

    // Normal scan, with a mid-frame change to digit 0
    n_rst = 1'b1;
    ticks(6);
    hex[0] = 7'h12;
    ticks(36);

    // Disable then re-enable
    en = 1'b0;
    ticks(3);
    en = 1'b1;
    ticks(13);
    en = 1'b0;
    ticks(2);
    en = 1'b1;
    ticks(21);

    // Asynchronous reset in the middle of cycle 20
    n_rst = 1'b0;
    #1;
    check_off("async_reset");
    ticks(2);
    n_rst = 1'b1;
    hex[0] = 7'h40;
    ticks(40);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scanner.md
# seg7_scanner

Time-multiplexing scanner that sits directly downstream of `seg7_controller`. It takes the per-digit segment patterns from the controller's `o_hex` array and drives a shared segment bus plus per-digit anode enables. This serves boards whose 7-segment displays are multiplexed rather than individually wired. It snapshots all digits once per frame, so a digit never changes part-way through a frame, and it inserts a blanking gap between digits to suppress ghosting.

## Interface
- `NUM_7SEGMENTS`, default 8: number of digits scanned; must be ≥1.
- `DIGIT_CYCLES`, default 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz).
- `BLANK_CYCLES`, default 500: cycles at the start of each slot during which everything is off; must satisfy 0 ≤ `BLANK_CYCLES` < `DIGIT_CYCLES`.
- `AN_ACTIVE_LOW`, default 1: 1 means an anode enable is driven 0 when its digit is on; 0 means it is driven 1.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `n_rst`, input, 1: reset, asynchronous and active-low.
- `i_en`, input, 1: scan enable; 0 forces the display off and restarts the frame.
- `i_hex`, input, [6:0] × [0:NUM_7SEGMENTS-1]: per-digit segment patterns, same encoding as `seg7_controller` `o_hex`. Bit = 0 means the segment is lit.
- `o_seg`, output, 7: shared segment bus, same encoding as `i_hex`.
- `o_an`, output, NUM_7SEGMENTS: per-digit anode enables; polarity is set by `AN_ACTIVE_LOW`.
- `o_frame_start`, output, 1: one-cycle pulse during cycle 0 of slot 0.

## Operation
- **State:**
  - slot counter `cnt`, width $clog2(DIGIT_CYCLES) (minimum 1);
  - digit index `dig`, width $clog2(NUM_7SEGMENTS) (minimum 1);
  - shadow array `shadow[0:N-1]` of 7-bit patterns;
  - phase FSM with states BLANK and ON.
- **Counting:**
  - `cnt` increments each cycle while `i_en`=1.
  - At `DIGIT_CYCLES-1`, `cnt` wraps to 0 and `dig` advances.
  - `dig` wraps from N-1 to 0. When N=1, `dig` stays 0.
- **FSM:**
  - BLANK while `cnt` < `BLANK_CYCLES`; ON while `cnt` ≥ `BLANK_CYCLES`.
  - BLANK→ON when `cnt` reaches `BLANK_CYCLES`.
  - ON→BLANK on slot wrap.
  - If `BLANK_CYCLES`=0, BLANK is never entered after the first slot: ON is continuous, and only `o_an` changes at slot boundaries.
- **Outputs in BLANK:** `o_seg` = 7'h7f (all off), `o_an` = all inactive.
- **Outputs in ON:** `o_seg` = `shadow[dig]`; only `o_an[dig]` is active.
- **Snapshot:**
  - All N entries of `i_hex` are captured into `shadow` on the edge that begins cycle 0 of slot 0.
  - Changes to `i_hex` at any other time have no visible effect until the next frame.
- **`o_frame_start`:** high exactly during cycle 0 of slot 0 of every frame.
- **Disable:**
  - `i_en`=0 sampled on an edge: in the following cycle all outputs are off, `o_frame_start`=0, and `cnt`, `dig` and the FSM reset to slot 0 / cycle 0 / BLANK.
  - `shadow` holds its contents.
- **Re-enable:** the first edge with `i_en`=1 after disable behaves like the first edge after reset. It begins cycle 0 of slot 0, takes a fresh snapshot and pulses `o_frame_start`.
- **Anode exclusivity:** at most one `o_an` bit is active in any cycle, including at slot boundaries and under disable.

## Timing
- **Outputs:** all outputs come from flops; there are no combinational paths from inputs to outputs.
- **Reset (asynchronous, while `n_rst`=0):**
  - `o_seg` = 7'h7f;
  - `o_an` = all inactive ({N{1}} if `AN_ACTIVE_LOW`, else 0);
  - `o_frame_start` = 0;
  - `cnt` = 0, `dig` = 0, FSM = BLANK, `shadow` = all 7'h7f.
- **Start after reset:** the first rising edge with `n_rst`=1 and `i_en`=1 begins cycle 0 of slot 0.
- **Frame timing:** slot s occupies cycles [s·D, (s+1)·D), where D = `DIGIT_CYCLES`. The frame period is N·D cycles.
- **Slot timing:** within slot s, cycles 0..B-1 are blank (B = `BLANK_CYCLES`); cycles B..D-1 drive digit s.
- **Snapshot latency:** a change to `i_hex` is visible at the earliest in cycle B of slot 0 of the next frame.
- **Reset mid-frame:** outputs go to their reset values immediately (asynchronously), with no partial-slot completion.

## Test plan
All scenarios use N=4, D=8, B=2, `AN_ACTIVE_LOW`=1, `i_en`=1, `i_hex` = {7'h40, 7'h79, 7'h24, 7'h30}.
- **Reset values:** hold `n_rst`=0 → `o_seg` = 7'h7f, `o_an` = 4'b1111, `o_frame_start` = 0.
- **Normal scan:** release reset →
  - cycles 0–1: `o_an` = 4'b1111, `o_seg` = 7'h7f;
  - cycles 2–7: `o_an` = 4'b1110, `o_seg` = 7'h40;
  - cycles 10–15: `o_an` = 4'b1101, `o_seg` = 7'h79;
  - cycles 26–31: `o_an` = 4'b0111, `o_seg` = 7'h30;
  - `o_frame_start` = 1 at cycles 0 and 32 only.
- **Frame snapshot:** change `i_hex[0]` to 7'h12 at cycle 5 → `o_seg` stays 7'h40 for cycles 5–7; `o_seg` = 7'h12 at cycles 34–39.
- **Disable/re-enable:** drop `i_en` at cycle 12 → from cycle 13, `o_an` = 4'b1111 and `o_seg` = 7'h7f. Raise `i_en` → `o_frame_start` pulses on the first enabled cycle, and digit 0 is lit 2 cycles later.
- **Async reset mid-slot:** assert `n_rst`=0 mid-cycle at cycle 20 → outputs go to their reset values before the next clock edge. After release, the scan restarts at slot 0.
- **No blanking:** with B=0 → there is no all-off cycle after cycle 0. Exactly one anode is active every cycle, and `o_an` changes at multiples of 8.
